// File: rtl/controle_sequencia.sv
// controle_sequencia: Moore control unit that sequences the 4-bit game datapath.
// Define TIMEOUT_EN to build the move-wait timer and the esgotado state.
module controle_sequencia #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera_n,
    output logic       conta,
    output logic       registra,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        st_inicial    = 4'h0,
        st_preparacao = 4'h1,
        st_espera     = 4'h2,
        st_registra   = 4'h4,
        st_comparacao = 4'h5,
        st_proximo    = 4'h6,
        st_fim_acerto = 4'hA,
        st_esgotado   = 4'hD,
        st_fim_erro   = 4'hE
    } estado_t;

    estado_t estado;
    estado_t proximo_estado;
    logic    expirou;

    if (TIMEOUT_CICLOS < 2) begin : g_parametro_invalido
        $error("controle_sequencia: TIMEOUT_CICLOS must be 2 or more");
    end

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CICLOS - 1);

    logic [TW-1:0] timer;

    // Timer is zero on every entry to espera because any other state clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (estado != st_espera) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    assign expirou = (timer == T_MAX);
`else
    assign expirou = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= st_inicial;
        end else begin
            estado <= proximo_estado;
        end
    end

    always_comb begin
        proximo_estado = st_inicial;
        case (estado)
            st_inicial:    proximo_estado = iniciar ? st_preparacao : st_inicial;
            st_preparacao: proximo_estado = st_espera;
            st_espera: begin
                if (jogada) begin
                    proximo_estado = st_registra;
                end else if (expirou) begin
`ifdef TIMEOUT_EN
                    proximo_estado = st_esgotado;
`else
                    proximo_estado = st_espera;
`endif
                end else begin
                    proximo_estado = st_espera;
                end
            end
            st_registra:   proximo_estado = st_comparacao;
            st_comparacao: begin
                if (!igual) begin
                    proximo_estado = st_fim_erro;
                end else if (fim) begin
                    proximo_estado = st_fim_acerto;
                end else begin
                    proximo_estado = st_proximo;
                end
            end
            st_proximo:    proximo_estado = st_espera;
            st_fim_acerto: proximo_estado = iniciar ? st_preparacao : st_fim_acerto;
            st_fim_erro:   proximo_estado = iniciar ? st_preparacao : st_fim_erro;
`ifdef TIMEOUT_EN
            st_esgotado:   proximo_estado = iniciar ? st_preparacao : st_esgotado;
`endif
            default:       proximo_estado = st_inicial;
        endcase
    end

    // Pure state decode; inicial also holds the datapath counter cleared.
    always_comb begin
        zera_n   = 1'b1;
        conta    = 1'b0;
        registra = 1'b0;
        pronto   = 1'b0;
        acertou  = 1'b0;
        errou    = 1'b0;
        timeout  = 1'b0;
        case (estado)
            st_inicial:    zera_n = 1'b0;
            st_preparacao: zera_n = 1'b0;
            st_registra:   registra = 1'b1;
            st_proximo:    conta = 1'b1;
            st_fim_acerto: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            st_fim_erro: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            st_esgotado: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_controle_sequencia.sv
// Directed testbench for controle_sequencia with a behavioural 74163-style counter
// standing in for the datapath so that fim follows the counter like the real board.
module tb_controle_sequencia;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim;
    logic       zera_n;
    logic       conta;
    logic       registra;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    logic [3:0] q;
    int         contaPulses;
    int         checks;
    int         passes;

    controle_sequencia #(.TIMEOUT_CICLOS(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .jogada   (jogada),
        .igual    (igual),
        .fim      (fim),
        .zera_n   (zera_n),
        .conta    (conta),
        .registra (registra),
        .pronto   (pronto),
        .acertou  (acertou),
        .errou    (errou),
        .timeout  (timeout),
        .db_estado(db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Datapath counter model: synchronous clear, count enable, ent tied high.
    initial q = 4'd0;
    always @(posedge clock) begin
        if (!zera_n) q <= 4'd0;
        else if (conta) q <= q + 4'd1;
    end
    assign fim = (q == 4'hF);

    initial contaPulses = 0;
    always @(posedge clock) if (conta) contaPulses++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
        tick(); tick();
        checks++; if (db_estado !== 4'h0) $display("[TB] FAIL reset_estado: got %h expected 0", db_estado); else passes++;
        checks++; if (zera_n !== 1'b0) $display("[TB] FAIL reset_zera_n: got %b expected 0", zera_n); else passes++;
        checks++; if ({conta, registra, pronto, acertou, errou, timeout} !== 6'b0)
            $display("[TB] FAIL reset_outputs: got %b expected 000000", {conta, registra, pronto, acertou, errou, timeout}); else passes++;
        reset = 1'b0;
        tick();
        checks++; if (db_estado !== 4'h0) $display("[TB] FAIL idle_hold: got %h expected 0", db_estado); else passes++;
    endtask

    task automatic start_round(input string name);
        iniciar = 1'b1;
        tick();
        checks++; if (db_estado !== 4'h1 || zera_n !== 1'b0)
            $display("[TB] FAIL %s_preparacao: got estado=%h zera_n=%b expected 1/0", name, db_estado, zera_n); else passes++;
        iniciar = 1'b0;
        tick();
        checks++; if (db_estado !== 4'h2 || q !== 4'd0)
            $display("[TB] FAIL %s_espera: got estado=%h q=%0d expected 2/0", name, db_estado, q); else passes++;
    endtask

    task automatic test_full_sequence();
        start_round("full");
        contaPulses = 0;
        for (int i = 0; i < 16; i++) begin
            jogada = 1'b1; igual = 1'b1;
            tick();
            jogada = 1'b0;
            if (i == 0) begin
                checks++; if (db_estado !== 4'h4 || registra !== 1'b1)
                    $display("[TB] FAIL full_registra: got estado=%h registra=%b expected 4/1", db_estado, registra); else passes++;
            end
            tick();
            if (i == 0) begin
                checks++; if (db_estado !== 4'h5) $display("[TB] FAIL full_comparacao: got %h expected 5", db_estado); else passes++;
            end
            tick();
            if (i < 15) begin
                if (i == 0) begin
                    checks++; if (db_estado !== 4'h6 || conta !== 1'b1)
                        $display("[TB] FAIL full_proximo: got estado=%h conta=%b expected 6/1", db_estado, conta); else passes++;
                end
                tick();
            end
        end
        checks++; if (contaPulses !== 15) $display("[TB] FAIL full_conta_pulses: got %0d expected 15", contaPulses); else passes++;
        checks++; if (db_estado !== 4'hA || acertou !== 1'b1 || pronto !== 1'b1)
            $display("[TB] FAIL full_fim_acerto: got estado=%h acertou=%b pronto=%b expected A/1/1", db_estado, acertou, pronto); else passes++;
        igual = 1'b0;
        tick(); tick(); tick();
        checks++; if (db_estado !== 4'hA || acertou !== 1'b1 || pronto !== 1'b1 || errou !== 1'b0)
            $display("[TB] FAIL full_hold: got estado=%h acertou=%b pronto=%b errou=%b expected A/1/1/0", db_estado, acertou, pronto, errou); else passes++;
    endtask

    task automatic test_miss_third();
        start_round("miss");
        contaPulses = 0;
        for (int i = 0; i < 3; i++) begin
            jogada = 1'b1; igual = (i < 2);
            tick();
            jogada = 1'b0;
            tick(); tick();
            if (i < 2) tick();
        end
        checks++; if (db_estado !== 4'hE || errou !== 1'b1 || pronto !== 1'b1 || acertou !== 1'b0)
            $display("[TB] FAIL miss_fim_erro: got estado=%h errou=%b pronto=%b acertou=%b expected E/1/1/0", db_estado, errou, pronto, acertou); else passes++;
        checks++; if (contaPulses !== 2) $display("[TB] FAIL miss_conta_pulses: got %0d expected 2", contaPulses); else passes++;
        checks++; if (q !== 4'd2) $display("[TB] FAIL miss_counter: got %0d expected 2", q); else passes++;
    endtask

    task automatic test_restart();
        iniciar = 1'b1;
        tick();
        checks++; if (db_estado !== 4'h1 || zera_n !== 1'b0)
            $display("[TB] FAIL restart_preparacao: got estado=%h zera_n=%b expected 1/0", db_estado, zera_n); else passes++;
        checks++; if ({acertou, errou, pronto} !== 3'b000)
            $display("[TB] FAIL restart_flags: got %b expected 000", {acertou, errou, pronto}); else passes++;
        iniciar = 1'b0;
        tick();
        checks++; if (db_estado !== 4'h2 || q !== 4'd0)
            $display("[TB] FAIL restart_espera: got estado=%h q=%0d expected 2/0", db_estado, q); else passes++;
    endtask

    task automatic test_dropped_move();
        jogada = 1'b1; igual = 1'b1;
        tick();
        jogada = 1'b0;
        tick(); tick();
        checks++; if (db_estado !== 4'h6) $display("[TB] FAIL drop_in_proximo: got %h expected 6", db_estado); else passes++;
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        tick(); tick(); tick();
        checks++; if (db_estado !== 4'h2 || registra !== 1'b0)
            $display("[TB] FAIL drop_ignored: got estado=%h registra=%b expected 2/0", db_estado, registra); else passes++;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL drop_timeout: got %b expected 0", timeout); else passes++;
    endtask

    task automatic test_async_reset();
        jogada = 1'b1; igual = 1'b1;
        tick();
        jogada = 1'b0;
        tick();
        checks++; if (db_estado !== 4'h5) $display("[TB] FAIL areset_setup: got %h expected 5", db_estado); else passes++;
        #2 reset = 1'b1;
        #1;
        checks++; if (db_estado !== 4'h0 || zera_n !== 1'b0)
            $display("[TB] FAIL areset_immediate: got estado=%h zera_n=%b expected 0/0", db_estado, zera_n); else passes++;
        checks++; if ({conta, registra, pronto, acertou, errou, timeout} !== 6'b0)
            $display("[TB] FAIL areset_outputs: got %b expected 000000", {conta, registra, pronto, acertou, errou, timeout}); else passes++;
        tick();
        checks++; if (q !== 4'd0) $display("[TB] FAIL areset_counter: got %0d expected 0", q); else passes++;
        reset = 1'b0;
        tick();
    endtask

`ifdef TIMEOUT_EN
    task automatic test_timeout();
        start_round("tmo");
        for (int i = 0; i < 7; i++) tick();
        checks++; if (db_estado !== 4'h2) $display("[TB] FAIL tmo_still_espera: got %h expected 2", db_estado); else passes++;
        tick();
        checks++; if (db_estado !== 4'hD || timeout !== 1'b1 || pronto !== 1'b1)
            $display("[TB] FAIL tmo_esgotado: got estado=%h timeout=%b pronto=%b expected D/1/1", db_estado, timeout, pronto); else passes++;
        start_round("tmo2");
        for (int i = 0; i < 7; i++) tick();
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        checks++; if (db_estado !== 4'h4 || timeout !== 1'b0)
            $display("[TB] FAIL tmo_jogada_wins: got estado=%h timeout=%b expected 4/0", db_estado, timeout); else passes++;
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_full_sequence();
        test_miss_third();
        test_restart();
        test_dropped_move();
        test_async_reset();
`ifdef TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/controle_sequencia.md
# controle_sequencia

Moore-style control unit that sequences the 4-bit game datapath: it clears and advances the 74163-style position counter, latches each player move, and reads the comparator and the terminal-count flag to decide hit, miss or end of sequence. It sits beside the datapath (counter, register, memory, comparator) and is the only driver of the counter's clear and enable lines. An optional move timeout is compiled in with a macro.

## Interface
- TIMEOUT_CICLOS, 5000: cycles allowed in the move-wait state before timeout. Used only with TIMEOUT_EN. Legal range is 2 or more.
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; forces state inicial.
- iniciar  in  1  start request; sampled in inicial and in the three final states.
- jogada  in  1  one-cycle move-valid pulse, already edge-detected upstream.
- igual  in  1  datapath comparator result: register contents equal memory contents.
- fim  in  1  counter terminal count. The datapath ties counter ent=1, so fim=1 exactly when Q==15.
- zera_n  out  1  active-low counter clear; wires directly to counter clr.
- conta  out  1  counter count enable; wires to enp.
- registra  out  1  load enable for the move register.
- pronto  out  1  high in any final state.
- acertou  out  1  high in fim_acerto.
- errou  out  1  high in fim_erro.
- timeout  out  1  high in esgotado. Constant 0 without TIMEOUT_EN.
- db_estado  out  4  current state code, for debug displays.

## Operation
- State codes:
  - inicial = 0
  - preparacao = 1
  - espera = 2
  - registra = 4
  - comparacao = 5
  - proximo = 6
  - fim_acerto = A
  - fim_erro = E
  - esgotado = D
- Any other code goes to inicial on the next clock.
- Transitions:
  - inicial: iniciar=1 goes to preparacao; otherwise stay.
  - preparacao: goes to espera unconditionally.
  - espera: jogada=1 goes to registra. With TIMEOUT_EN, the timeout condition goes to esgotado. Otherwise stay.
  - registra: goes to comparacao unconditionally.
  - comparacao: igual=0 goes to fim_erro. igual=1 with fim=1 goes to fim_acerto. igual=1 with fim=0 goes to proximo.
  - proximo: goes to espera unconditionally.
  - fim_acerto, fim_erro, esgotado: iniciar=1 goes to preparacao (restart without passing through inicial); otherwise hold.
- Outputs are decoded from state only; there are no Mealy outputs.
  - zera_n=0 only in preparacao and inicial; 1 in all other states.
  - conta=1 only in proximo.
  - registra=1 only in registra.
  - pronto=1 in fim_acerto, fim_erro and esgotado.
- A move is ignored in every state except espera. A jogada pulse arriving in registra, comparacao or proximo is dropped, not queued.
- igual and fim are sampled only in comparacao. Their values in any other state have no effect.

## Timing
- Reset:
  - State goes to inicial immediately, without waiting for a clock.
  - While reset is high: zera_n=0, conta=0, registra=0, pronto=0, acertou=0, errou=0, timeout=0, db_estado=0.
- Reset asserted mid-operation aborts the round. The counter is cleared on the next clock edge through zera_n=0.
- State register updates on the rising edge of clock; outputs change in the same cycle as the new state.
- Start latency: iniciar is sampled high in cycle n, then the state is preparacao in n+1 and espera in n+2. The counter reads 0 from the edge that ends n+1.
- Per move: jogada is sampled in espera in cycle m. Then registra is at m+1, comparacao at m+2, proximo at m+3 and espera at m+4. The counter increments on the edge ending m+3.
- Final state is reached at m+3 when the last comparison fails, or when it hits with fim=1.
- The 16th hit (Q==15) ends the round; the counter is never wrapped by this block.
- Timeout (TIMEOUT_EN only):
  - The internal timer clears on every entry to espera and increments in each cycle spent in espera.
  - Width is $clog2(TIMEOUT_CICLOS).
  - When the timer equals TIMEOUT_CICLOS-1 and jogada=0, the next state is esgotado.
  - If jogada=1 in that same cycle, jogada wins and the next state is registra.

## Configuration
- Macro: TIMEOUT_EN.
- Defined: the timeout timer is built, the esgotado state is reachable, and the timeout output is live.
- Undefined: no timer logic is built; espera waits indefinitely; timeout is tied to 0; state code D falls under the unused-code rule and goes to inicial.

## Test plan
- Asynchronous reset:
  - Stimulus: assert reset mid-clock while in comparacao.
  - Response: db_estado=0 and zera_n=0 before the next clock edge; all other outputs 0.
- Full sequence:
  - Stimulus: iniciar pulse, then 16 jogada pulses each with igual=1; fim=1 only on the 16th compare.
  - Response: 15 conta pulses; db_estado=A; acertou=1 and pronto=1 held until iniciar.
- Miss on the third move:
  - Stimulus: igual=0 at the third comparacao.
  - Response: db_estado=E and errou=1; exactly 2 conta pulses were issued.
- Restart from a final state:
  - Stimulus: iniciar=1 while in fim_erro.
  - Response: preparacao next cycle with zera_n=0, then espera; acertou, errou and pronto return to 0.
- Dropped move:
  - Stimulus: a jogada pulse during proximo.
  - Response: ignored; state stays in espera waiting for a new pulse.
- Timeout (TIMEOUT_EN, TIMEOUT_CICLOS=8):
  - Stimulus 1: no jogada after entering espera.
    - Response: esgotado after 8 cycles in espera, with timeout=1 and pronto=1.
  - Stimulus 2: jogada arrives in the 8th espera cycle.
    - Response: next state is registra, not esgotado.
